shift_add_controller: RTL and testbench
=======================================

SHIFT_ADD_CONTROLLER -- requirements
Module: shift_add_controller

Interface
REQ-001 Parameters: none; operand width SHALL be fixed at 4 bits, product width at 8 bits.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Start  input  1  request to begin a multiplication.
REQ-005 Multiplicando  input  4  unsigned multiplicand, sampled only when a Start is accepted.
REQ-006 Multiplicador  input  4  unsigned multiplier, sampled only when a Start is accepted.
REQ-007 Produto  output  8  registered unsigned product.
REQ-008 Pronto  output  1  one-cycle pulse marking a valid new Produto.
REQ-009 Ocupado  output  1  high while an operation is in progress (states ADD, SHIFT, DONE).

Function
REQ-010 The FSM SHALL have exactly the states IDLE, ADD, SHIFT and DONE, encoded as the shared enum.
REQ-011 IDLE: when Start=1, the block SHALL accept at that edge: M<=Multiplicando, Q<=Multiplicador, {C,A}<=0, count<=0, and go to ADD; otherwise it SHALL stay in IDLE.
REQ-012 ADD: when Q[0]=1, the block SHALL set {C,A}<=A+M (5-bit sum through the adder); otherwise {C,A}<={1'b0,A}; next state SHALL be SHIFT.
REQ-013 SHIFT: {C,A,Q}<={1'b0,C,A,Q[3:1]}; count<=count+1; next state SHALL be DONE if count was 3, else ADD.
REQ-014 DONE: Produto<={A,Q} at entry; Pronto=1 for exactly this one cycle; next state SHALL be IDLE.
REQ-015 Latency: Start accepted at edge k, so Pronto=1 and the new Produto are visible in cycle k+9 (8 ADD/SHIFT cycles then DONE); Ocupado SHALL be high in cycles k+1..k+9.
REQ-016 Start while Ocupado=1 (including during DONE) SHALL be ignored with no queuing; a Start that is held is accepted at the first IDLE cycle, which allows back-to-back operations every 10 cycles.
REQ-017 Produto SHALL hold its last value until the next DONE and SHALL NOT change during ADD or SHIFT.
REQ-018 Operand changes after acceptance SHALL have no effect on the result in progress.
REQ-019 The carry C SHALL never be lost: 15x15 SHALL yield 225.

Reset
REQ-020 Reset=1 at an edge SHALL force state IDLE, Produto=0, Pronto=0, Ocupado=0, and {C,A,Q,M}=0, count=0, in any state.
REQ-021 Reset SHALL take priority over Start at the same edge; an aborted operation SHALL produce no Pronto pulse.

Configuration
REQ-022 With ZERO_SKIP_EN defined: when Multiplicando=0 or Multiplicador=0 at acceptance, the FSM SHALL go IDLE->DONE directly, with Produto=0 and Pronto=1 in cycle k+1.
REQ-023 Without ZERO_SKIP_EN: every operation, zeros included, SHALL take the full latency of REQ-015.

Structure
REQ-024 A shared package SHALL hold the FSM state enum, the constants OP_WIDTH=4, PROD_WIDTH=8 and ITERATIONS=4.
REQ-025 The existing Adder (4+4 to 5-bit) SHALL be instantiated as the only sub-module to form {C,A}+M; the controller SHALL contain no other arithmetic except the counter increment.

Verification
REQ-026 Start with 3x5 -> Pronto in cycle k+9, Produto=15, Ocupado high in k+1..k+9.
REQ-027 Start with 15x15 -> Produto=225 (carry path); then 7x8 immediately after IDLE -> Produto=56.
REQ-028 Start pulsed again in cycle k+4 with 2x2 during 9x6 -> ignored, Produto=54, single Pronto pulse.
REQ-029 Reset asserted in cycle k+5 of 13x11 -> IDLE next cycle, Produto=0, no Pronto; then 13x11 -> 143.
REQ-030 Start with 0x9: with ZERO_SKIP_EN -> Pronto at k+1, Produto=0; without it -> Pronto at k+9, Produto=0.
REQ-031 Start with 15x15 followed by 1x1 -> Produto=1 proves that A and C are cleared on acceptance.

Source files
------------

// File: rtl/shift_add_controller_pkg.sv
// Shared definitions for the shift-and-add multiplier controller:
// FSM state encoding, operand/product widths and the iteration count.
package shift_add_controller_pkg;

  localparam int OP_WIDTH   = 4;
  localparam int PROD_WIDTH = 8;
  localparam int ITERATIONS = 4;
  localparam int CNT_W      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_add_controller_adder.sv
// Unsigned 4+4 -> 5-bit adder; the carry-out becomes the C bit of the
// partial-product accumulator.
module shift_add_controller_adder
  import shift_add_controller_pkg::*;
(
  input  logic [OP_WIDTH-1:0] a_i,
  input  logic [OP_WIDTH-1:0] b_i,
  output logic [OP_WIDTH:0]   sum_o
);

  assign sum_o = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/shift_add_controller.sv
// Sequential 4x4 unsigned shift-and-add multiplier controller.
// One ADD/SHIFT pair per multiplier bit, then a single DONE cycle that
// presents the product and pulses pronto_o.
// Optional build macro: ZERO_SKIP_EN -- a zero operand at acceptance jumps
// straight to DONE with a zero product (one-cycle latency).
module shift_add_controller
  import shift_add_controller_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [OP_WIDTH-1:0]   multiplicando_i,
  input  logic [OP_WIDTH-1:0]   multiplicador_i,
  output logic [PROD_WIDTH-1:0] produto_o,
  output logic                  pronto_o,
  output logic                  ocupado_o
);

  state_t                state_q;
  logic                  c_q;
  logic [OP_WIDTH-1:0]   a_q;
  logic [OP_WIDTH-1:0]   q_q;
  logic [OP_WIDTH-1:0]   m_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [PROD_WIDTH-1:0] produto_q;
  logic                  pronto_q;
  logic                  ocupado_q;
  logic [OP_WIDTH:0]     sum_d;

  // C is always zero when ADD is entered (cleared on accept and by SHIFT),
  // so A+M through the adder is the full {C,A}+M.
  shift_add_controller_adder u_adder (
    .a_i   (a_q),
    .b_i   (m_q),
    .sum_o (sum_d)
  );

  // Controller FSM with datapath registers and registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      c_q       <= 1'b0;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      cnt_q     <= '0;
      produto_q <= '0;
      pronto_q  <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          pronto_q <= 1'b0;
          if (start_i) begin
            m_q       <= multiplicando_i;
            q_q       <= multiplicador_i;
            c_q       <= 1'b0;
            a_q       <= '0;
            cnt_q     <= '0;
            ocupado_q <= 1'b1;
`ifdef ZERO_SKIP_EN
            if (multiplicando_i == '0 || multiplicador_i == '0) begin
              state_q   <= DONE;
              produto_q <= '0;
              pronto_q  <= 1'b1;
            end else begin
              state_q <= ADD;
            end
`else
            state_q <= ADD;
`endif
          end
        end
        ADD: begin
          if (q_q[0]) {c_q, a_q} <= sum_d;
          else        {c_q, a_q} <= {1'b0, a_q};
          state_q <= SHIFT;
        end
        SHIFT: begin
          {c_q, a_q, q_q} <= {1'b0, c_q, a_q, q_q[OP_WIDTH-1:1]};
          cnt_q           <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(ITERATIONS - 1)) begin
            // Capture the post-shift {A,Q} so DONE presents the final product
            produto_q <= {c_q, a_q, q_q[OP_WIDTH-1:1]};
            pronto_q  <= 1'b1;
            state_q   <= DONE;
          end else begin
            state_q <= ADD;
          end
        end
        DONE: begin
          pronto_q  <= 1'b0;
          ocupado_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign produto_o = produto_q;
  assign pronto_o  = pronto_q;
  assign ocupado_o = ocupado_q;

endmodule

// File: tb/tb_shift_add_controller.sv
// Directed self-checking bench for shift_add_controller.
module tb_shift_add_controller;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] mcand;
  logic [3:0] mplier;
  logic [7:0] produto;
  logic       pronto;
  logic       ocupado;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] last_p;

  shift_add_controller dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .multiplicando_i (mcand),
    .multiplicador_i (mplier),
    .produto_o       (produto),
    .pronto_o        (pronto),
    .ocupado_o       (ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands with start for one edge (edge k), then scramble operands.
  task automatic start_op(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    start  = 1'b1;
    mcand  = a;
    mplier = b;
    @(posedge clk);
    #1;
    start  = 1'b0;
    mcand  = 4'($urandom);
    mplier = 4'($urandom);
  endtask

  // Observe cycles k+1..k+lat+2; optional ignored Start pulse in cycle k+inj.
  task automatic wait_done(input string tag, input int lat, input logic [7:0] exp_p,
                           input int inj);
    int pulses = 0, first = 0, busy_bad = 0, hold_bad = 0;
    logic [7:0] got_p = 8'h0;
    for (int i = 1; i <= lat + 2; i++) begin
      @(negedge clk);
      if (i == inj + 1) start = 1'b0;
      if (ocupado !== (i <= lat)) busy_bad++;
      if (pronto === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
      end
      if (i < lat && produto !== last_p) hold_bad++;
      if (i == lat) got_p = produto;
      if (i == inj) begin
        start = 1'b1; mcand = 4'd2; mplier = 4'd2;
      end
    end
    chk({tag, "_lat"},    first,    lat);
    chk({tag, "_pulses"}, pulses,   1);
    chk({tag, "_prod"},   got_p,    exp_p);
    chk({tag, "_busy"},   busy_bad, 0);
    chk({tag, "_hold"},   hold_bad, 0);
    last_p = exp_p;
  endtask

  task automatic op(input string tag, input logic [3:0] a, input logic [3:0] b,
                    input logic [7:0] exp_p, input int inj);
    int lat = 9;
`ifdef ZERO_SKIP_EN
    if (a == 4'd0 || b == 4'd0) lat = 1;
`endif
    start_op(a, b);
    wait_done(tag, lat, exp_p, inj);
  endtask

  initial begin
    int pulses, p1, p2, stray;
    rst = 1'b1; start = 1'b0; mcand = 4'd0; mplier = 4'd0;
    last_p = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_prod", produto, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_busy", ocupado, 0);
    rst = 1'b0;

    op("3x5",   4'd3,  4'd5,  8'd15,  0);
    op("15x15", 4'd15, 4'd15, 8'd225, 0);
    op("7x8",   4'd7,  4'd8,  8'd56,  0);
    op("9x6",   4'd9,  4'd6,  8'd54,  4);   // Start mid-operation ignored
    op("6x7",   4'd6,  4'd7,  8'd42,  9);   // Start during DONE ignored
    op("15x15b",4'd15, 4'd15, 8'd225, 0);
    op("1x1",   4'd1,  4'd1,  8'd1,   0);   // A and C cleared on accept
    op("0x9",   4'd0,  4'd9,  8'd0,   0);
    op("12x10", 4'd12, 4'd10, 8'd120, 0);

    // Reset in cycle k+5 of 13x11 aborts with no Pronto
    start_op(4'd13, 4'd11);
    stray = 0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (pronto === 1'b1) stray++;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", ocupado, 0);
    chk("abort_prod", produto, 0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pronto === 1'b1) stray++;
    end
    chk("abort_nopronto", stray, 0);
    last_p = 8'd0;
    op("13x11", 4'd13, 4'd11, 8'd143, 0);

    // Reset wins over Start at the same edge
    @(negedge clk);
    rst = 1'b1; start = 1'b1; mcand = 4'd5; mplier = 4'd5;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_prio_busy", ocupado, 0);
    chk("rst_prio_prod", produto, 0);
    last_p = 8'd0;

    // Held Start: back-to-back operations every 10 cycles
    @(negedge clk);
    start = 1'b1; mcand = 4'd2; mplier = 4'd3;
    @(posedge clk);
    pulses = 0; p1 = 0; p2 = 0;
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (pronto === 1'b1) begin
        pulses++;
        if (p1 == 0) p1 = i; else p2 = i;
        chk("held_prod", produto, 6);
      end
      if (i == 12) start = 1'b0;
    end
    chk("held_pulses", pulses, 2);
    chk("held_first", p1, 9);
    chk("held_second", p2, 19);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
